// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
// This package holds the FSM states, the requester ids and the memory mode encodings.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic REQ_IF     = 1'b0;
    localparam logic REQ_EX     = 1'b1;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker. It is purely combinational.
// The last-grant pointer register lives in the parent.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            // On a tie, grant the requester that was not served last.
            if (last == REQ_IF) begin
                gnt[REQ_EX] = 1'b1;
            end else begin
                gnt[REQ_IF] = 1'b1;
            end
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch requester and the load/store requester.
// Each access holds the port for MEM_LAT cycles and then returns a one-cycle rvalid pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ex_req,
    input  logic              ex_we,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ex_gnt,
    output logic              ex_rvalid,
    output logic [DATA_W-1:0] ex_rdata,
    output logic              mem_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end

    localparam logic [3:0] LAT4 = 4'(MEM_LAT);

    state_t            state, state_nx;
    logic              last;
    logic              owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        cnt;
    logic [1:0]        arb_gnt;
    logic              grant_any;
    logic              win;

    rr_arb2 u_arb (
        .req  ({ex_req, if_req}),
        .last (last),
        .gnt  (arb_gnt)
    );

    // The reset term in the grant keeps the grant outputs low while reset is held.
    assign if_gnt    = (state == IDLE) && rst && arb_gnt[REQ_IF];
    assign ex_gnt    = (state == IDLE) && rst && arb_gnt[REQ_EX];
    assign grant_any = if_gnt || ex_gnt;
    assign win       = ex_gnt ? REQ_EX : REQ_IF;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_any) state_nx = BUSY;
            BUSY:    if (cnt == 4'd1) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last     <= REQ_IF;
            owner    <= REQ_IF;
            we_q     <= MODE_READ;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt      <= '0;
            if_rdata <= '0;
            ex_rdata <= '0;
        end else begin
            if (state == IDLE && grant_any) begin
                owner   <= win;
                last    <= win;
                addr_q  <= (win == REQ_EX) ? ex_addr : if_addr;
                // Fetch never writes, so its grants always latch a read.
                we_q    <= (win == REQ_EX) ? ex_we : MODE_READ;
                wdata_q <= (win == REQ_EX) ? ex_wdata : '0;
                cnt     <= LAT4;
            end
            if (state == BUSY) begin
                cnt <= cnt - 4'd1;
                if (cnt == 4'd1) begin
                    if (owner == REQ_IF) begin
                        if_rdata <= mem_data_out;
                    end else begin
                        ex_rdata <= (we_q == MODE_WRITE) ? '0 : mem_data_out;
                    end
                end
            end
        end
    end

    assign busy        = (state != IDLE);
    assign mem_mode    = (state == BUSY) ? we_q : MODE_READ;
    assign mem_addr    = (state == BUSY) ? addr_q : '0;
    assign mem_data_in = (state == BUSY) ? wdata_q : '0;
    assign if_rvalid   = (state == RESP) && (owner == REQ_IF);
    assign ex_rvalid   = (state == RESP) && (owner == REQ_EX);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one memory port of the VEDA_MIPS block between the instruction-fetch requester and the execute-stage load/store requester. It arbitrates between the two with a 2-way round-robin, registers the winning request, and holds the memory port for a fixed access latency. It returns read data, or a write acknowledge, with a one-cycle valid pulse. It sits between Instruction_Fetch / Instruction_Execute and VEDA_MIPS, so the design can run on a single-port memory.

## Interface
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- MEM_LAT, 1, cycles the port is held per access; legal range 1..15
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-low reset
- if_req  input  1  fetch read request; held until if_gnt
- if_addr  input  ADDR_W  fetch address
- if_gnt  output  1  fetch request accepted this cycle (combinational)
- if_rvalid  output  1  one-cycle pulse; if_rdata valid
- if_rdata  output  DATA_W  fetched word
- ex_req  input  1  data request; held until ex_gnt
- ex_we  input  1  1 = write, 0 = read
- ex_addr  input  ADDR_W  data address
- ex_wdata  input  DATA_W  store data
- ex_gnt  output  1  data request accepted this cycle (combinational)
- ex_rvalid  output  1  one-cycle pulse; read data valid, or write done
- ex_rdata  output  DATA_W  load data; 0 for writes
- mem_mode  output  1  VEDA mode: 1 = write, 0 = read
- mem_addr  output  ADDR_W  VEDA address
- mem_data_in  output  DATA_W  VEDA write data
- mem_data_out  input  DATA_W  VEDA read data
- busy  output  1  state != IDLE

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE**
  - If any req is high, the winner gets a combinational gnt.
  - At the clock edge, latch the winner's id, address, we and wdata.
  - Load the latency counter with MEM_LAT and go to BUSY.
- **Arbitration**
  - Only one requester active: it wins.
  - Both active: the requester not granted last wins.
  - The last-grant pointer updates on every grant. Reset value = fetch, so ex wins the first tie.
- **BUSY**
  - Drive mem_addr, mem_mode and mem_data_in from the latched registers.
  - Decrement the counter each cycle.
  - On the edge where the counter reaches 1: capture mem_data_out into the winner's rdata (reads only), then go to RESP.
- **RESP**
  - Pulse the winner's rvalid for one cycle, then go to IDLE.
  - Writes pulse ex_rvalid with ex_rdata = 0.
- **Outside BUSY**: mem_mode = 0, mem_addr = 0, mem_data_in = 0.
- **Request protocol**
  - Requests are never granted outside IDLE; if_gnt and ex_gnt are held 0 in BUSY and RESP.
  - A requester that drops req before gnt withdraws cleanly; nothing is latched.
- **Write requests from fetch**: fetch never issues writes; mem_mode is forced 0 for fetch grants.
- **Read-data hold**: if_rdata and ex_rdata hold their last value until the next completion for that requester.

## Timing
- **Reset (rst low, asynchronous)**
  - State = IDLE, pointer = fetch.
  - All outputs 0: gnt, rvalid, rdata, mem_*, busy.
  - Reset during BUSY aborts the access; mem_mode drops to 0 immediately and no rvalid is produced.
- **Access timeline (grant in cycle T)**
  - Cycles T+1 .. T+MEM_LAT: BUSY, port driven.
  - Cycle T+MEM_LAT+1: rvalid high.
  - Cycle T+MEM_LAT+2: next grant possible.
- Throughput: one access per MEM_LAT+2 cycles.
- Read latency, from gnt to rvalid: MEM_LAT+1 cycles.
- busy = 1 from T+1 through T+MEM_LAT+1.
- A requester holding req through RESP is granted in the following IDLE cycle, subject to round-robin.
- **Counter**: 4 bits wide; MEM_LAT values 0 and >15 are rejected by an elaboration-time check.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY, RESP}
  - requester ids REQ_IF = 0, REQ_EX = 1
  - VEDA mode constants MODE_READ = 0, MODE_WRITE = 1
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], last-grant bit.
  - Output: one-hot gnt[1:0].
  - Purely combinational; the pointer register lives in the parent.

## Test plan
- Reset, then if_req = 1 with if_addr = 0x10 and MEM_LAT = 1:
  - if_gnt in cycle 0.
  - mem_addr = 0x10 in cycle 1.
  - if_rvalid in cycle 2 with if_rdata equal to memory word 0x10.
- ex_req with ex_we = 1, ex_addr = 0x40, ex_wdata = 0xDEADBEEF, MEM_LAT = 3:
  - mem_mode = 1 for exactly 3 cycles.
  - ex_rvalid pulses with ex_rdata = 0.
  - A following read of 0x40 returns 0xDEADBEEF.
- if_req and ex_req both held high for 4 grants: grant order ex, if, ex, if; no gnt ever asserted while busy = 1.
- ex_req pulsed high for one cycle while BUSY, then dropped: no ex_gnt and no ex_rvalid.
- rst pulled low in the second BUSY cycle of a write with MEM_LAT = 3:
  - mem_mode goes to 0 without waiting for a clock edge; busy = 0; no rvalid.
  - After reset, a tie is won by ex.
- Continuous if_req with MEM_LAT = 2: if_rvalid on every 4th cycle; if_rdata stable between pulses.
